// File: rtl/uart_tx_with_parity_core.sv
// Multi-word UART transmitter: one handshake loads W_OUT bits, which are sent as
// NUM_WORDS back-to-back packets (start, data LSB first, even parity, stop bits).
module uart_tx_with_parity_core #(
   parameter int CLOCKS_PER_PULSE = 4,
   parameter int BITS_PER_WORD    = 8,
   parameter int PACKET_SIZE      = 13,
   parameter int W_OUT            = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [W_OUT-1:0] s_data,
   output logic             tx,
   output logic             parity
);

   localparam int NUM_WORDS = W_OUT / BITS_PER_WORD;
   localparam int NUM_STOP  = PACKET_SIZE - BITS_PER_WORD - 2;
   localparam int MAX_BITS  = (BITS_PER_WORD > NUM_STOP) ? BITS_PER_WORD : NUM_STOP;
   localparam int CW        = (CLOCKS_PER_PULSE > 1) ? $clog2(CLOCKS_PER_PULSE) : 1;
   localparam int BW        = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;
   localparam int WW        = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t                   r_state;
   logic [W_OUT-1:0]         r_data;
   logic [BITS_PER_WORD-1:0] r_shift;
   logic [CW-1:0]            r_clk;
   logic [BW-1:0]            r_bit;
   logic [WW-1:0]            r_word;
   logic                     r_tx;
   logic                     r_ready;
   logic                     r_parity;

   logic [BITS_PER_WORD-1:0] w_words [NUM_WORDS];
   logic [WW-1:0]            w_word_nxt;

   // r_data stays frozen for the whole transfer; words are picked by index.
   always_comb begin
      for (int unsigned i = 0; i < NUM_WORDS; i++) begin
         w_words[i] = r_data[i*BITS_PER_WORD +: BITS_PER_WORD];
      end
      w_word_nxt = r_word + WW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_data   <= '0;
         r_shift  <= '0;
         r_clk    <= '0;
         r_bit    <= '0;
         r_word   <= '0;
         r_tx     <= 1'b1;
         r_ready  <= 1'b1;
         r_parity <= 1'b0;
      end else if (r_state == S_IDLE) begin
         if (s_valid && r_ready) begin
            r_data   <= s_data;
            r_shift  <= s_data[BITS_PER_WORD-1:0];
            r_parity <= ^s_data[BITS_PER_WORD-1:0];
            r_clk    <= '0;
            r_bit    <= '0;
            r_word   <= '0;
            r_tx     <= 1'b0;
            r_ready  <= 1'b0;
            r_state  <= S_START;
         end
      end else if (r_clk != CW'(CLOCKS_PER_PULSE - 1)) begin
         r_clk <= r_clk + CW'(1);
      end else begin
         r_clk <= '0;
         case (r_state)
            S_START: begin
               r_tx    <= r_shift[0];
               r_shift <= r_shift >> 1;
               r_bit   <= '0;
               r_state <= S_DATA;
            end
            S_DATA: begin
               if (r_bit == BW'(BITS_PER_WORD - 1)) begin
                  r_tx    <= r_parity;
                  r_state <= S_PARITY;
               end else begin
                  r_tx    <= r_shift[0];
                  r_shift <= r_shift >> 1;
                  r_bit   <= r_bit + BW'(1);
               end
            end
            S_PARITY: begin
               r_tx    <= 1'b1;
               r_bit   <= '0;
               r_state <= S_STOP;
            end
            S_STOP: begin
               if (r_bit != BW'(NUM_STOP - 1)) begin
                  r_bit <= r_bit + BW'(1);
               end else if (r_word == WW'(NUM_WORDS - 1)) begin
                  r_ready  <= 1'b1;
                  r_parity <= 1'b0;
                  r_word   <= '0;
                  r_bit    <= '0;
                  r_state  <= S_IDLE;
               end else begin
                  // Next word's start bit follows the last stop bit with no gap.
                  r_word   <= w_word_nxt;
                  r_shift  <= w_words[w_word_nxt];
                  r_parity <= ^w_words[w_word_nxt];
                  r_bit    <= '0;
                  r_tx     <= 1'b0;
                  r_state  <= S_START;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign s_ready = r_ready;
   assign tx      = r_tx;
   assign parity  = r_parity;

endmodule

// File: tb/tb_uart_tx_with_parity_core.sv
// Scoreboard bench for uart_tx_with_parity_core: stimulus queues hand-computed words,
// a mid-bit sampling UART receiver pops and checks each received packet.
module tb_uart_tx_with_parity_core;

   localparam int CPP   = 4;
   localparam int BPW   = 8;
   localparam int PS    = 13;
   localparam int NSTOP = PS - BPW - 2;
   localparam int XFER  = 2 * PS * CPP;

   typedef struct packed {
      logic [7:0] d;
      logic       p;
   } exp_t;

   typedef struct packed {
      logic [15:0] data;
      logic [7:0]  w0;
      logic        p0;
      logic [7:0]  w1;
      logic        p1;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic [15:0] s_data = '0;
   logic        tx;
   logic        parity;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   uart_tx_with_parity_core #(
      .CLOCKS_PER_PULSE(CPP),
      .BITS_PER_WORD(BPW),
      .PACKET_SIZE(PS),
      .W_OUT(16)
   ) dut (
      .clk(clk),
      .rst(rst),
      .s_valid(s_valid),
      .s_ready(s_ready),
      .s_data(s_data),
      .tx(tx),
      .parity(parity)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push2(input logic [7:0] w0, input logic p0, input logic [7:0] w1, input logic p1);
      q.push_back('{d: w0, p: p0});
      q.push_back('{d: w1, p: p1});
   endtask

   // Called at posedge+#1 with s_ready high; returns at posedge+#1 after the accepting edge.
   task automatic accept(input logic [15:0] d);
      s_valid = 1'b1;
      s_data  = d;
      @(posedge clk); #1;
      s_valid = 1'b0;
      chk("accept_ready_low", 32'(s_ready), 32'(0));
      chk("accept_start_bit", 32'(tx), 32'(0));
   endtask

   task automatic wait_ready(output int cyc);
      cyc = 0;
      do begin
         @(posedge clk); #1;
         cyc++;
      end while (!s_ready && cyc < 300);
      if (!s_ready) chk("ready_timeout", 32'(0), 32'(1));
   endtask

   // Receiver: detects the start bit, samples each bit at mid-period.
   initial begin : monitor
      exp_t           e;
      logic [PS-1:0]  fr;
      logic           pp_start;
      logic           pp_par;
      bit             ab;
      int             nb;
      forever begin
         @(negedge clk);
         if (!rst && tx === 1'b0) begin
            if (q.size() == 0) begin
               chk("unexpected_start", 32'(0), 32'(1));
            end else begin
               e        = q.pop_front();
               ab       = 1'b0;
               fr       = '0;
               nb       = 0;
               pp_start = 1'b0;
               pp_par   = 1'b0;
               for (int c = 0; c < PS * CPP; c++) begin
                  if (c != 0) @(negedge clk);
                  if (rst) begin
                     ab = 1'b1;
                     break;
                  end
                  if (c % CPP == CPP / 2) begin
                     fr = {tx, fr[PS-1:1]};
                     if (nb == 0) pp_start = parity;
                     if (nb == BPW + 1) pp_par = parity;
                     nb++;
                  end
               end
               if (!ab) begin
                  chk("start_bit", 32'(fr[0]), 32'(0));
                  chk("data_bits", 32'(fr[BPW:1]), 32'(e.d));
                  chk("parity_bit", 32'(fr[BPW+1]), 32'(e.p));
                  chk("stop_bits", 32'(fr[PS-1:BPW+2]), 32'({NSTOP{1'b1}}));
                  chk("parity_port_start", 32'(pp_start), 32'(e.p));
                  chk("parity_port_pbit", 32'(pp_par), 32'(e.p));
               end
            end
         end
      end
   end

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog: simulation exceeded time limit");
      n_bad++;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      vec_t vecs[6];
      int   cyc;
      vecs[0] = '{data: 16'h0000, w0: 8'h00, p0: 1'b0, w1: 8'h00, p1: 1'b0};
      vecs[1] = '{data: 16'h8001, w0: 8'h01, p0: 1'b1, w1: 8'h80, p1: 1'b1};
      vecs[2] = '{data: 16'h55AA, w0: 8'hAA, p0: 1'b0, w1: 8'h55, p1: 1'b0};
      vecs[3] = '{data: 16'h7F80, w0: 8'h80, p0: 1'b1, w1: 8'h7F, p1: 1'b1};
      vecs[4] = '{data: 16'hC3E7, w0: 8'hE7, p0: 1'b0, w1: 8'hC3, p1: 1'b0};
      vecs[5] = '{data: 16'h0B10, w0: 8'h10, p0: 1'b1, w1: 8'h0B, p1: 1'b1};

      // Reset state with s_valid asserted: must be ignored.
      s_valid = 1'b1;
      s_data  = 16'h1111;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_tx", 32'(tx), 32'(1));
      chk("reset_ready", 32'(s_ready), 32'(1));
      chk("reset_parity", 32'(parity), 32'(0));
      rst     = 1'b0;
      s_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("idle_tx", 32'(tx), 32'(1));

      // 0x0701: two words, both odd count of ones.
      push2(8'h01, 1'b1, 8'h07, 1'b1);
      accept(16'h0701);
      wait_ready(cyc);
      chk("xfer_cycles_0701", 32'(cyc), 32'(XFER));
      chk("done_tx_idle", 32'(tx), 32'(1));
      chk("done_parity_zero", 32'(parity), 32'(0));

      // 0xA53C with s_valid held and s_data changed mid-transfer; 0x1234 then follows back-to-back.
      push2(8'h3C, 1'b0, 8'hA5, 1'b0);
      push2(8'h34, 1'b1, 8'h12, 1'b0);
      s_valid = 1'b1;
      s_data  = 16'hA53C;
      @(posedge clk); #1;
      s_data = 16'h1234;
      chk("hold_ready_low", 32'(s_ready), 32'(0));
      wait_ready(cyc);
      chk("xfer_cycles_A53C", 32'(cyc), 32'(XFER));
      @(posedge clk); #1;
      s_valid = 1'b0;
      chk("b2b_start_bit", 32'(tx), 32'(0));
      chk("b2b_ready_low", 32'(s_ready), 32'(0));
      wait_ready(cyc);
      chk("xfer_cycles_1234", 32'(cyc), 32'(XFER));

      // Reset during word 1 data bits; second word is discarded by the receiver.
      push2(8'h81, 1'b0, 8'h5A, 1'b0);
      accept(16'h5A81);
      repeat (59) @(posedge clk);
      #1;
      rst     = 1'b1;
      s_valid = 1'b1;
      s_data  = 16'h3333;
      @(posedge clk); #1;
      chk("abort_tx", 32'(tx), 32'(1));
      chk("abort_ready", 32'(s_ready), 32'(1));
      chk("abort_parity", 32'(parity), 32'(0));
      rst     = 1'b0;
      s_valid = 1'b0;
      @(posedge clk); #1;
      chk("post_abort_ready", 32'(s_ready), 32'(1));
      chk("post_abort_tx", 32'(tx), 32'(1));
      push2(8'hFF, 1'b0, 8'hFF, 1'b0);
      accept(16'hFFFF);
      wait_ready(cyc);
      chk("xfer_cycles_FFFF", 32'(cyc), 32'(XFER));

      // Directed table with random idle gaps.
      foreach (vecs[i]) begin
         repeat ($urandom_range(1, 20)) @(posedge clk);
         #1;
         push2(vecs[i].w0, vecs[i].p0, vecs[i].w1, vecs[i].p1);
         accept(vecs[i].data);
         wait_ready(cyc);
         chk("xfer_cycles_tbl", 32'(cyc), 32'(XFER));
      end

      repeat (5) @(posedge clk);
      #1;
      chk("queue_drained", 32'(q.size()), 32'(0));
      chk("final_tx", 32'(tx), 32'(1));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/uart_tx_with_parity_core.md
UART_TX_WITH_PARITY_CORE -- requirements
Module: uart_tx_with_parity

Interface
REQ-001 SHALL have parameter CLOCKS_PER_PULSE, default 4: clock cycles per UART bit, integer >= 2.
REQ-002 SHALL have parameter BITS_PER_WORD, default 8: data bits per UART packet.
REQ-003 SHALL have parameter PACKET_SIZE, default 13: total bits per packet (start + data + parity + stops), >= BITS_PER_WORD+3.
REQ-004 SHALL have parameter W_OUT, default 16: width of s_data, an integer multiple of BITS_PER_WORD; NUM_WORDS = W_OUT/BITS_PER_WORD.
REQ-005 SHALL have port clk, input, 1: single clock, all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-007 SHALL have port s_valid, input, 1: input word valid.
REQ-008 SHALL have port s_ready, output, 1: block idle and able to accept s_data.
REQ-009 SHALL have port s_data, input, W_OUT: payload, packed as NUM_WORDS words of BITS_PER_WORD bits; word 0 = s_data[BITS_PER_WORD-1:0].
REQ-010 SHALL have port tx, output, 1: serial UART line, idle high.
REQ-011 SHALL have port parity, output, 1: even-parity bit of the word currently being transmitted (0 when idle).

Function
REQ-012 SHALL be in IDLE with tx=1 and s_ready=1 when no transfer is in progress.
REQ-013 SHALL accept s_data on a rising edge where s_valid=1 and s_ready=1, register all W_OUT bits, and deassert s_ready from the next cycle.
REQ-014 SHALL ignore s_valid and s_data while s_ready=0; registered data SHALL NOT change during transmission.
REQ-015 SHALL drive the start bit (tx=0) beginning the cycle after the accepting edge.
REQ-016 SHALL hold every bit on tx for exactly CLOCKS_PER_PULSE cycles.
REQ-017 SHALL send each packet as: start bit 0; BITS_PER_WORD data bits LSB first; one parity bit; PACKET_SIZE-BITS_PER_WORD-2 stop bits of 1 (3 with defaults).
REQ-018 SHALL compute the parity bit as the XOR of the word's data bits (even parity: total ones in data+parity even).
REQ-019 SHALL send words 0 to NUM_WORDS-1 in ascending order, each next start bit directly following the previous packet's last stop bit, no idle gap.
REQ-020 SHALL take exactly NUM_WORDS*PACKET_SIZE*CLOCKS_PER_PULSE cycles from first start-bit cycle to end of last stop bit (104 with defaults).
REQ-021 SHALL reassert s_ready and return to IDLE (tx=1) in the cycle right after the last stop bit of the last word ends.
REQ-022 SHALL accept a new handshake in the first cycle s_ready is high again, giving back-to-back transfers.
REQ-023 SHALL use states IDLE -> START -> DATA -> PARITY -> STOP -> (START for next word | IDLE after last word), with a bit-period counter 0..CLOCKS_PER_PULSE-1, a bit index counter and a word index counter.
REQ-024 SHALL size all counters to the required ranges, with no wrap other than the explicit per-bit/per-word rollovers.
REQ-025 SHALL update the parity output when a word's start bit begins and hold it through that packet.

Reset
REQ-026 SHALL, with rst=1 at a rising edge, force IDLE, tx=1, s_ready=1, parity=0, and clear all counters and the data register.
REQ-027 SHALL abort any transfer on reset mid-packet, without finishing the packet; tx SHALL be 1 from the cycle after the reset edge.
REQ-028 SHALL ignore s_valid while rst=1.

Verification
REQ-029 Defaults, s_data=16'h0701 -> packet 0: 0,1000_0000,1,111; packet 1: 0,1110_0000,1,111 (data LSB first, each bit 4 cycles), then s_ready=1 exactly 104 cycles after first start cycle.
REQ-030 s_data=16'hA53C -> data bits 0011_1100 then 1010_0101 (LSB first), parity 0 for both words, stop bits all 1.
REQ-031 s_valid held high after accept while s_ready=0, s_data changed -> transmitted payload is the originally accepted value.
REQ-032 rst asserted during word 1 data bits -> tx=1 and s_ready=1 from the following cycle; a new s_data=16'hFFFF is then sent with parity 0 for both words.
REQ-033 Ten random payloads with random 1-20 cycle idle gaps -> a UART receiver sampling mid-bit recovers each payload exactly, and every parity bit matches the XOR of its word.
REQ-034 Back-to-back: s_valid asserted in the first cycle s_ready returns high -> the next start bit begins the following cycle.
